// File: rtl/axi4_lite_master_arbiter.sv
// Two-requester round-robin arbiter in front of the AXI4-Lite master command port; write and read channels run independently.
// Latency req->done is busy cycles + 3. Requesters hold req until their done pulse; the downstream port paces each channel through busy.
module axi4_lite_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  i_wr_req,
  input  logic [2*ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0]     i_wr_data,
  input  logic [2*(DATA_WIDTH/8)-1:0] i_wr_strobe,
  output logic [1:0]                  o_wr_done,
  input  logic [1:0]                  i_rd_req,
  input  logic [2*ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0]       o_rd_data,
  output logic [1:0]                  o_rd_done,
  output logic [1:0]                  o_wr_grant,
  output logic [1:0]                  o_rd_grant,
  output logic                        o_write_start,
  output logic [ADDR_WIDTH-1:0]       o_write_addr,
  output logic [DATA_WIDTH-1:0]       o_write_data,
  output logic [DATA_WIDTH/8-1:0]     o_write_strobe,
  input  logic                        i_write_busy,
  output logic                        o_read_start,
  output logic [ADDR_WIDTH-1:0]       o_read_addr,
  input  logic [DATA_WIDTH-1:0]       i_read_data,
  input  logic                        i_read_busy
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t          r_wr_state, w_wr_next;
  state_t          r_rd_state, w_rd_next;
  logic [1:0]      r_wr_grant, r_rd_grant;
  logic            r_wr_last, r_rd_last;
  logic            w_wr_sel, w_rd_sel;
  logic            r_write_start, r_read_start;
  logic [AW-1:0]   r_write_addr, r_read_addr;
  logic [DW-1:0]   r_write_data, r_rd_data;
  logic [SW-1:0]   r_write_strobe;

  // Winner index: on contention the requester that did not own the channel last goes first.
  function automatic logic rr_sel(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  assign w_wr_sel = rr_sel(i_wr_req, r_wr_last);
  assign w_rd_sel = rr_sel(i_rd_req, r_rd_last);

  // start is registered off START, so it is still high in the first WAIT cycle and doubles as the minimum-dwell marker.
  always_comb begin
    w_wr_next = r_wr_state;
    o_wr_done = 2'b00;
    case (r_wr_state)
      S_IDLE:  if (|i_wr_req) w_wr_next = S_START;
      S_START: w_wr_next = S_WAIT;
      S_WAIT:  if (!i_write_busy && !r_write_start) w_wr_next = S_DONE;
      S_DONE: begin
        o_wr_done = r_wr_grant;
        w_wr_next = S_IDLE;
      end
      default: w_wr_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state     <= S_IDLE;
      r_wr_grant     <= 2'b00;
      r_wr_last      <= 1'b1;
      r_write_start  <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_write_strobe <= '0;
    end else begin
      r_wr_state    <= w_wr_next;
      r_write_start <= (r_wr_state == S_START);
      if (r_wr_state == S_IDLE && |i_wr_req) begin
        r_wr_grant     <= w_wr_sel ? 2'b10 : 2'b01;
        r_write_addr   <= w_wr_sel ? i_wr_addr[2*AW-1:AW]   : i_wr_addr[AW-1:0];
        r_write_data   <= w_wr_sel ? i_wr_data[2*DW-1:DW]   : i_wr_data[DW-1:0];
        r_write_strobe <= w_wr_sel ? i_wr_strobe[2*SW-1:SW] : i_wr_strobe[SW-1:0];
      end else if (r_wr_state == S_DONE) begin
        r_wr_grant <= 2'b00;
        r_wr_last  <= r_wr_grant[1];
      end
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    o_rd_done = 2'b00;
    case (r_rd_state)
      S_IDLE:  if (|i_rd_req) w_rd_next = S_START;
      S_START: w_rd_next = S_WAIT;
      S_WAIT:  if (!i_read_busy && !r_read_start) w_rd_next = S_DONE;
      S_DONE: begin
        o_rd_done = r_rd_grant;
        w_rd_next = S_IDLE;
      end
      default: w_rd_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state   <= S_IDLE;
      r_rd_grant   <= 2'b00;
      r_rd_last    <= 1'b1;
      r_read_start <= 1'b0;
      r_read_addr  <= '0;
      r_rd_data    <= '0;
    end else begin
      r_rd_state   <= w_rd_next;
      r_read_start <= (r_rd_state == S_START);
      if (r_rd_state == S_IDLE && |i_rd_req) begin
        r_rd_grant  <= w_rd_sel ? 2'b10 : 2'b01;
        r_read_addr <= w_rd_sel ? i_rd_addr[2*AW-1:AW] : i_rd_addr[AW-1:0];
      end else if (r_rd_state == S_DONE) begin
        r_rd_grant <= 2'b00;
        r_rd_last  <= r_rd_grant[1];
      end
      // Same condition as the WAIT->DONE step: read_data is valid as busy falls.
      if (r_rd_state == S_WAIT && !i_read_busy && !r_read_start)
        r_rd_data <= i_read_data;
    end
  end

  assign o_wr_grant     = r_wr_grant;
  assign o_rd_grant     = r_rd_grant;
  assign o_write_start  = r_write_start;
  assign o_write_addr   = r_write_addr;
  assign o_write_data   = r_write_data;
  assign o_write_strobe = r_write_strobe;
  assign o_read_start   = r_read_start;
  assign o_read_addr    = r_read_addr;
  assign o_rd_data      = r_rd_data;

endmodule
